// File: rtl/sdram_write_burst_engine_pkg.sv
// Shared definitions for the SDRAM write burst engine: command encodings,
// FSM state type and wait-timer sizing.
package sdram_write_burst_engine_pkg;

  // SDRAM commands as {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;

  // Address bit that selects precharge-all on a PRE command
  localparam int A10_BIT = 10;

  // Wait timer width; large enough for any tRCD/tWR/tRP setting up to 15 clocks
  localparam int TMR_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ACT,
    S_TRCD,
    S_WRITE,
    S_TWR,
    S_PRE,
    S_TRP
  } state_e;

  // Convert a clock count into a timer load value
  function automatic logic [TMR_W-1:0] tmr_cycles(input int n);
    return TMR_W'(n);
  endfunction

endpackage

// File: rtl/sdram_wr_timer.sv
// Loadable down-counter used for the tRCD / tWR / tRP waits.
// Loading N makes the following N cycles the wait; done marks the last of them
// and almost_done the one before it.
module sdram_wr_timer
  import sdram_write_burst_engine_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done,
  output logic             almost_done
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Next count: reload on request, otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TMR_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done        = (cnt_q == TMR_W'(1));
  assign almost_done = (cnt_q == TMR_W'(2));

endmodule

// File: rtl/sdram_write_burst_engine.sv
// SDRAM write engine: drains a FWFT write cache into SDRAM as ACT, one or
// more back-to-back WRITE bursts in the same row, then PRE.
//
// Bus handshake: arbit_write_req is raised in REQ and held until
// arbit_write_ack is sampled high; the engine then owns the bus until the
// write_end cycle. Ack is a level; dropping it (or refresh_req rising) is
// only acted on at a burst boundary, so a started burst always completes.
//
// Supported timing: T_RCD >= 2, T_WR >= 1, 2 <= T_RP <= 15.
module sdram_write_burst_engine
  import sdram_write_burst_engine_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ROW_W     = 13,
  parameter int COL_W     = 9,
  parameter int BANK_W    = 2,
  parameter int BURST_LEN = 4,
  parameter int T_RCD     = 2,
  parameter int T_WR      = 2,
  parameter int T_RP      = 2
) (
  input  logic                            sysclk_100M,
  input  logic                            rst_n,
  input  logic                            write_ready,
  input  logic                            wr_addr_load,
  input  logic [BANK_W+ROW_W+COL_W-1:0]   wr_start_addr,
  input  logic [DATA_W-1:0]               wr_data_in,
  output logic                            wr_data_rd_en,
  output logic                            arbit_write_req,
  input  logic                            arbit_write_ack,
  input  logic                            refresh_req,
  output logic                            burst_end,
  output logic                            write_end,
  output logic [3:0]                      cmd_reg,
  output logic [ROW_W-1:0]                sdram_addr,
  output logic [BANK_W-1:0]               sdram_bank_addr,
  output logic [DATA_W-1:0]               sdram_dq_out,
  output logic                            sdram_dq_oe,
  output state_e                          dbg_state,
  output logic [BANK_W+ROW_W+COL_W-1:0]   dbg_addr_ctr
);

  localparam int A_W    = BANK_W + ROW_W + COL_W;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_e              state_q, state_d;
  logic [A_W-1:0]      ctr_q, ctr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [ROW_W-1:0]    addr_q, addr_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic                req_q, req_d;
  logic                dq_oe_q, dq_oe_d;
  logic                burst_end_q, burst_end_d;
  logic                write_end_q, write_end_d;

  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_done;
  logic                tmr_almost_done;

  logic [COL_W-1:0]    ctr_col;
  logic [ROW_W-1:0]    ctr_row;
  logic [BANK_W-1:0]   ctr_bank;
  logic [A_W-1:0]      ctr_inc;
  logic                last_beat;
  logic                row_end;
  logic                stream_on;

  assign ctr_col  = ctr_q[COL_W-1:0];
  assign ctr_row  = ctr_q[COL_W +: ROW_W];
  assign ctr_bank = ctr_q[A_W-1 -: BANK_W];
  // Increment carries naturally from column into row and bank, and wraps at all-ones
  assign ctr_inc  = ctr_q + A_W'(BURST_LEN);

  assign last_beat = (beat_q == BEAT_W'(BURST_LEN - 1));
  // Current burst is the last one that fits in the open row
  assign row_end   = ((ctr_col | COL_W'(BURST_LEN - 1)) == {COL_W{1'b1}});
  // Another burst may follow without closing the row
  assign stream_on = write_ready && !refresh_req && arbit_write_ack && !row_end;

  sdram_wr_timer u_timer (
    .clk         (sysclk_100M),
    .rst_n       (rst_n),
    .load        (tmr_load),
    .load_val    (tmr_val),
    .done        (tmr_done),
    .almost_done (tmr_almost_done)
  );

  // Next state plus next values of every registered output
  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    beat_d      = '0;
    cmd_d       = CMD_NOP;
    addr_d      = addr_q;
    bank_d      = bank_q;
    req_d       = 1'b0;
    dq_oe_d     = 1'b0;
    burst_end_d = 1'b0;
    write_end_d = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    case (state_q)
      S_IDLE: begin
        if (wr_addr_load) begin
          ctr_d = wr_start_addr;
        end else if (write_ready && !refresh_req) begin
          state_d = S_REQ;
          req_d   = 1'b1;
        end
      end

      S_REQ: begin
        if (refresh_req) begin
          state_d = S_IDLE;
        end else if (arbit_write_ack) begin
          state_d = S_ACT;
          cmd_d   = CMD_ACT;
          addr_d  = ctr_row;
          bank_d  = ctr_bank;
        end else begin
          req_d = 1'b1;
        end
      end

      S_ACT: begin
        state_d  = S_TRCD;
        tmr_load = 1'b1;
        tmr_val  = tmr_cycles(T_RCD - 1);
      end

      S_TRCD: begin
        if (tmr_done) begin
          state_d     = S_WRITE;
          cmd_d       = CMD_WRITE;
          addr_d      = ROW_W'(ctr_col);
          bank_d      = ctr_bank;
          dq_oe_d     = 1'b1;
          burst_end_d = (BURST_LEN == 1);
        end
      end

      S_WRITE: begin
        if (!last_beat) begin
          beat_d      = beat_q + BEAT_W'(1);
          dq_oe_d     = 1'b1;
          burst_end_d = (beat_d == BEAT_W'(BURST_LEN - 1));
        end else begin
          ctr_d = ctr_inc;
          if (stream_on) begin
            cmd_d       = CMD_WRITE;
            addr_d      = ROW_W'(ctr_inc[COL_W-1:0]);
            dq_oe_d     = 1'b1;
            burst_end_d = (BURST_LEN == 1);
          end else begin
            state_d  = S_TWR;
            tmr_load = 1'b1;
            tmr_val  = tmr_cycles(T_WR);
          end
        end
      end

      S_TWR: begin
        if (tmr_done) begin
          state_d = S_PRE;
          cmd_d   = CMD_PRE;
          addr_d  = ROW_W'(1) << A10_BIT;
        end
      end

      S_PRE: begin
        state_d     = S_TRP;
        tmr_load    = 1'b1;
        tmr_val     = tmr_cycles(T_RP - 1);
        write_end_d = (T_RP == 2);
      end

      S_TRP: begin
        if (tmr_done) begin
          state_d = S_IDLE;
        end else begin
          write_end_d = tmr_almost_done;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ctr_q       <= '0;
      beat_q      <= '0;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      bank_q      <= '0;
      req_q       <= 1'b0;
      dq_oe_q     <= 1'b0;
      burst_end_q <= 1'b0;
      write_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      beat_q      <= beat_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      bank_q      <= bank_d;
      req_q       <= req_d;
      dq_oe_q     <= dq_oe_d;
      burst_end_q <= burst_end_d;
      write_end_q <= write_end_d;
    end
  end

  assign cmd_reg         = cmd_q;
  assign sdram_addr      = addr_q;
  assign sdram_bank_addr = bank_q;
  assign arbit_write_req = req_q;
  assign sdram_dq_oe     = dq_oe_q;
  assign burst_end       = burst_end_q;
  assign write_end       = write_end_q;
  // FWFT cache: the head word is valid now, so pop and drive in the same beat
  assign wr_data_rd_en   = dq_oe_q;
  assign sdram_dq_out    = dq_oe_q ? wr_data_in : '0;
  assign dbg_state       = state_q;
  assign dbg_addr_ctr    = ctr_q;

endmodule
